// File: rtl/ctr_pkg.sv
// Shared CTR definitions: requester IDs, the tag type that carries them
// through the in-order tag FIFO, and the default outstanding-read depth.
package ctr_pkg;

   typedef logic tag_t;

   localparam tag_t REQ_FPS       = 1'b0;
   localparam tag_t REQ_KNN       = 1'b1;
   localparam int   TAG_DEPTH_DEF = 4;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester tags, one entry per outstanding GLB read.
// Full/empty derive only from registered count so they never depend on this cycle's pop.
module tag_fifo
   import ctr_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  tag_t din,
   output logic full,
   output logic empty,
   output tag_t head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   tag_t           mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/crd_rd_arb.sv
// Shares the GLB coordinate-read channel between FPS and KNN: per-beat round-robin
// on addresses, tag-FIFO routing of returned words. Optional counters: CRD_RD_ARB_STAT_EN.
module crd_rd_arb
   import ctr_pkg::*;
#(
   parameter int IDX_WIDTH  = 10,
   parameter int SRAM_WIDTH = 256,
   parameter int TAG_DEPTH  = TAG_DEPTH_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  CCUCTR_Rst,
   input  logic [IDX_WIDTH-1:0]  FPSARB_CrdAddr,
   input  logic                  FPSARB_CrdAddrVld,
   output logic                  ARBFPS_CrdAddrRdy,
   output logic [SRAM_WIDTH-1:0] ARBFPS_Crd,
   output logic                  ARBFPS_CrdVld,
   input  logic                  FPSARB_CrdRdy,
   input  logic [IDX_WIDTH-1:0]  KNNARB_CrdAddr,
   input  logic                  KNNARB_CrdAddrVld,
   output logic                  ARBKNN_CrdAddrRdy,
   output logic [SRAM_WIDTH-1:0] ARBKNN_Crd,
   output logic                  ARBKNN_CrdVld,
   input  logic                  KNNARB_CrdRdy,
   output logic [IDX_WIDTH-1:0]  CTRGLB_CrdAddr,
   output logic                  CTRGLB_CrdAddrVld,
   input  logic                  GLBCTR_CrdAddrRdy,
   input  logic [SRAM_WIDTH-1:0] GLBCTR_Crd,
   input  logic                  GLBCTR_CrdVld,
   output logic                  CTRGLB_CrdRdy,
`ifdef CRD_RD_ARB_STAT_EN
   output logic [15:0]           ARBCCU_FpsGntCnt,
   output logic [15:0]           ARBCCU_KnnGntCnt,
   output logic [15:0]           ARBCCU_FullCnt,
`endif
   output logic                  ARBCCU_Err
);

   logic rst_all;
   logic any_req;
   logic gnt_knn;
   logic tag_full;
   logic tag_empty;
   logic addr_hs;
   logic data_hs;
   tag_t head;
   tag_t rr_ptr;
   tag_t grantee;
   logic err;

   assign rst_all = rst | CCUCTR_Rst;
   assign any_req = FPSARB_CrdAddrVld | KNNARB_CrdAddrVld;

   // Grant is a function of requests and the RR pointer only; GLB ready never feeds back into it.
   assign gnt_knn = (FPSARB_CrdAddrVld & KNNARB_CrdAddrVld) ? (rr_ptr == REQ_KNN)
                                                            : KNNARB_CrdAddrVld;
   assign grantee = gnt_knn ? REQ_KNN : REQ_FPS;

   assign CTRGLB_CrdAddrVld = any_req & ~tag_full;
   assign CTRGLB_CrdAddr    = gnt_knn ? KNNARB_CrdAddr : FPSARB_CrdAddr;
   assign ARBFPS_CrdAddrRdy = FPSARB_CrdAddrVld & ~gnt_knn & ~tag_full & GLBCTR_CrdAddrRdy;
   assign ARBKNN_CrdAddrRdy = gnt_knn & ~tag_full & GLBCTR_CrdAddrRdy;
   assign addr_hs           = CTRGLB_CrdAddrVld & GLBCTR_CrdAddrRdy;

   // Return path: the head tag steers the word; with no tag outstanding the word is sunk.
   assign ARBFPS_Crd    = GLBCTR_Crd;
   assign ARBKNN_Crd    = GLBCTR_Crd;
   assign ARBFPS_CrdVld = GLBCTR_CrdVld & ~tag_empty & (head == REQ_FPS);
   assign ARBKNN_CrdVld = GLBCTR_CrdVld & ~tag_empty & (head == REQ_KNN);
   assign CTRGLB_CrdRdy = tag_empty ? 1'b1 : ((head == REQ_KNN) ? KNNARB_CrdRdy : FPSARB_CrdRdy);
   assign data_hs       = GLBCTR_CrdVld & CTRGLB_CrdRdy & ~tag_empty;
   assign ARBCCU_Err    = err;

   tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst_all),
      .push  (addr_hs),
      .pop   (data_hs),
      .din   (grantee),
      .full  (tag_full),
      .empty (tag_empty),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (rst_all) begin
         rr_ptr <= REQ_FPS;
         err    <= 1'b0;
      end else begin
         if (addr_hs) rr_ptr <= gnt_knn ? REQ_FPS : REQ_KNN;
         if (GLBCTR_CrdVld & tag_empty) err <= 1'b1;
      end
   end

`ifdef CRD_RD_ARB_STAT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst_all) begin
         ARBCCU_FpsGntCnt <= '0;
         ARBCCU_KnnGntCnt <= '0;
         ARBCCU_FullCnt   <= '0;
      end else begin
         if (addr_hs & ~gnt_knn)   ARBCCU_FpsGntCnt <= sat_inc(ARBCCU_FpsGntCnt);
         if (addr_hs & gnt_knn)    ARBCCU_KnnGntCnt <= sat_inc(ARBCCU_KnnGntCnt);
         if (any_req & tag_full)   ARBCCU_FullCnt   <= sat_inc(ARBCCU_FullCnt);
      end
   end
`endif

endmodule
